sys_cmd_ctrl: RTL and testbench

UART command controller in the REF_CLK domain of SYS_TOP. It takes bytes from the UART RX path, decodes the four-command frame protocol, and sequences the register file and the ALU. Read data and ALU results are returned as bytes to the TX path. It is the only master of the register file and ALU ports, and it owns the ALU clock-gate enable.

---
 rtl/sys_cmd_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// UART command controller: decodes RF write/read and ALU command frames, drives the
// register file and ALU, and returns results to TX. Optional idle-gap timeout under CMD_TIMEOUT_EN.
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [ADDR_WIDTH-1:0]    RF_Address,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_VLD,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_BUSY,
    output logic                     CMD_ERROR
);

    // state       | meaning
    // ST_IDLE     | waiting for a command byte
    // ST_WR_ADDR  | RF write: waiting for address
    // ST_WR_DATA  | RF write: waiting for data
    // ST_RD_ADDR  | RF read: waiting for address
    // ST_RD_WAIT  | RF read issued, waiting for read data
    // ST_ALU_A    | waiting for operand A (to RF 0x0)
    // ST_ALU_B    | waiting for operand B (to RF 0x1)
    // ST_ALU_FUN  | waiting for function code
    // ST_ALU_WAIT | ALU running, waiting for result
    // ST_TX_LO    | sending low (or only) response byte
    // ST_TX_HI    | sending high ALU response byte
    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
        ST_ALU_A, ST_ALU_B, ST_ALU_FUN, ST_ALU_WAIT, ST_TX_LO, ST_TX_HI
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    state_t                   state_q, state_d;
    logic [ALU_OUT_WIDTH-1:0] resp_q, resp_d;
    logic                     is_alu_q, is_alu_d;
    logic                     wr_en_d, rd_en_d, alu_en_d, gate_d, tx_vld_d, err_d;
    logic [ADDR_WIDTH-1:0]    addr_d;
    logic [DATA_WIDTH-1:0]    wdata_d, tx_data_d;
    logic [3:0]               fun_d;
    logic                     waiting;
    logic                     timeout;

    assign waiting = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                     (state_q == ST_RD_ADDR) || (state_q == ST_ALU_A)   ||
                     (state_q == ST_ALU_B)   || (state_q == ST_ALU_FUN);

`ifdef CMD_TIMEOUT_EN
    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] gap_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                      gap_q <= '0;
        else if (!waiting || RX_D_VLD) gap_q <= '0;
        else                          gap_q <= gap_q + 16'd1;
    end

    // A byte arriving on the last cycle still wins over the timeout.
    assign timeout = waiting && !RX_D_VLD && (gap_q == GAP_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        is_alu_d  = is_alu_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        err_d     = 1'b0;
        addr_d    = RF_Address;
        wdata_d   = RF_WrData;
        alu_en_d  = ALU_EN;
        fun_d     = ALU_FUN;
        gate_d    = CLK_GATE_EN;
        tx_data_d = TX_P_DATA;

        case (state_q)
            ST_IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_WR:     state_d = ST_WR_ADDR;
                    CMD_RD:     state_d = ST_RD_ADDR;
                    CMD_ALU_OP: state_d = ST_ALU_A;
                    CMD_ALU:    state_d = ST_ALU_FUN;
                    default:    err_d   = 1'b1;
                endcase
            end
            ST_WR_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = ST_WR_DATA;
            end
            ST_WR_DATA: if (RX_D_VLD) begin
                wr_en_d = 1'b1;
                wdata_d = RX_P_DATA;
                state_d = ST_IDLE;
            end
            ST_RD_ADDR: if (RX_D_VLD) begin
                rd_en_d  = 1'b1;
                addr_d   = RX_P_DATA[ADDR_WIDTH-1:0];
                is_alu_d = 1'b0;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (RF_RdData_VLD) begin
                resp_d  = ALU_OUT_WIDTH'(RF_RdData);
                state_d = ST_TX_LO;
            end
            ST_ALU_A: if (RX_D_VLD) begin
                wr_en_d = 1'b1;
                addr_d  = '0;
                wdata_d = RX_P_DATA;
                state_d = ST_ALU_B;
            end
            ST_ALU_B: if (RX_D_VLD) begin
                wr_en_d = 1'b1;
                addr_d  = ADDR_WIDTH'(1);
                wdata_d = RX_P_DATA;
                state_d = ST_ALU_FUN;
            end
            ST_ALU_FUN: if (RX_D_VLD) begin
                alu_en_d = 1'b1;
                gate_d   = 1'b1;
                fun_d    = RX_P_DATA[3:0];
                is_alu_d = 1'b1;
                state_d  = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: if (ALU_OUT_VLD) begin
                resp_d   = ALU_OUT;
                alu_en_d = 1'b0;
                gate_d   = 1'b0;
                state_d  = ST_TX_LO;
            end
            // The !TX_D_VLD guard keeps back-to-back TX writes two cycles apart.
            ST_TX_LO: if (!TX_BUSY && !TX_D_VLD) begin
                tx_vld_d  = 1'b1;
                tx_data_d = resp_q[DATA_WIDTH-1:0];
                state_d   = is_alu_q ? ST_TX_HI : ST_IDLE;
            end
            ST_TX_HI: if (!TX_BUSY && !TX_D_VLD) begin
                tx_vld_d  = 1'b1;
                tx_data_d = resp_q[ALU_OUT_WIDTH-1:DATA_WIDTH];
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            resp_q      <= '0;
            is_alu_q    <= 1'b0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERROR   <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            is_alu_q    <= is_alu_d;
            RF_WrEn     <= wr_en_d;
            RF_RdEn     <= rd_en_d;
            RF_Address  <= addr_d;
            RF_WrData   <= wdata_d;
            ALU_EN      <= alu_en_d;
            ALU_FUN     <= fun_d;
            CLK_GATE_EN <= gate_d;
            TX_P_DATA   <= tx_data_d;
            TX_D_VLD    <= tx_vld_d;
            CMD_ERROR   <= err_d;
        end
    end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed self-checking bench for sys_cmd_ctrl: RF write/read, both ALU commands,
// TX backpressure, unknown command, reset mid-command, and timeout when CMD_TIMEOUT_EN is set.
module tb_sys_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic        RF_WrEn, RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData = '0;
    logic        RF_RdData_VLD = 1'b0;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY = 1'b0;
    logic        CMD_ERROR;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [7:0] tx_q[$];
    int         tx_cyc[$];

    sys_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .CMD_ERROR(CMD_ERROR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (TX_D_VLD) begin
            tx_q.push_back(TX_P_DATA);
            tx_cyc.push_back(cyc);
        end
        if (RF_WrEn) wr_cnt++;
        if (RF_RdEn) rd_cnt++;
        if (CMD_ERROR) err_cnt++;
        if (RF_WrEn && RF_RdEn) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // After return the byte has been sampled and the resulting strobes are visible.
    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_tx(input string tag, input int n);
        int k = 0;
        while (tx_q.size() < n && k < 50) begin
            @(negedge CLK); #1;
            k++;
        end
        chk(tag, tx_q.size(), n);
    endtask

    function automatic logic [29:0] all_out();
        return {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERROR};
    endfunction

    initial begin
        tick(3);
        chk("reset_outputs", all_out(), 0);
        RST = 1'b0;
        tick(2);

        // RF write 0xA6 -> 0x5
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'hA6);
        chk("wr_en", RF_WrEn, 1);
        chk("wr_addr", RF_Address, 4'h5);
        chk("wr_data", RF_WrData, 8'hA6);
        chk("wr_rd_en_low", RF_RdEn, 0);
        tick(1);
        chk("wr_en_one_cycle", RF_WrEn, 0);
        tick(5);
        chk("wr_no_tx", tx_q.size(), 0);

        // RF read 0x5 -> returns 0xA6
        send_byte(8'hBB);
        send_byte(8'h05);
        chk("rd_en", RF_RdEn, 1);
        chk("rd_addr", RF_Address, 4'h5);
        chk("rd_wr_en_low", RF_WrEn, 0);
        tick(1);
        chk("rd_en_one_cycle", RF_RdEn, 0);
        RF_RdData = 8'hA6;
        RF_RdData_VLD = 1'b1;
        tick(1);
        RF_RdData_VLD = 1'b0;
        wait_tx("rd_tx_count", 1);
        chk("rd_tx_byte", tx_q[0], 8'hA6);
        tick(6);
        chk("rd_tx_single", tx_q.size(), 1);
        tx_q.delete();
        tx_cyc.delete();

        // ALU with operands: A=0x0A, B=0x03, FUN=0 -> 0x000D
        send_byte(8'hCC);
        send_byte(8'h0A);
        chk("aluop_a_wr", RF_WrEn, 1);
        chk("aluop_a_addr", RF_Address, 4'h0);
        chk("aluop_a_data", RF_WrData, 8'h0A);
        send_byte(8'h03);
        chk("aluop_b_wr", RF_WrEn, 1);
        chk("aluop_b_addr", RF_Address, 4'h1);
        chk("aluop_b_data", RF_WrData, 8'h03);
        send_byte(8'hF0);
        chk("aluop_en", ALU_EN, 1);
        chk("aluop_gate", CLK_GATE_EN, 1);
        chk("aluop_fun", ALU_FUN, 4'h0);
        tick(3);
        chk("aluop_en_held", ALU_EN, 1);
        ALU_OUT = 16'h000D;
        ALU_OUT_VLD = 1'b1;
        tick(1);
        ALU_OUT_VLD = 1'b0;
        chk("aluop_en_drop", ALU_EN, 0);
        chk("aluop_gate_drop", CLK_GATE_EN, 0);
        wait_tx("aluop_tx_count", 2);
        chk("aluop_tx_lo", tx_q[0], 8'h0D);
        chk("aluop_tx_hi", tx_q[1], 8'h00);
        chk("aluop_tx_gap", (tx_cyc[1] - tx_cyc[0]) >= 2, 1);
        chk("wr_count_3", wr_cnt, 3);
        tx_q.delete();
        tx_cyc.delete();

        // ALU without operands, FUN=1 -> 0x1234, TX busy for 20 cycles
        TX_BUSY = 1'b1;
        send_byte(8'hDD);
        send_byte(8'h31);
        chk("alu_en", ALU_EN, 1);
        chk("alu_fun", ALU_FUN, 4'h1);
        tick(2);
        ALU_OUT = 16'h1234;
        ALU_OUT_VLD = 1'b1;
        tick(1);
        ALU_OUT_VLD = 1'b0;
        tick(20);
        chk("busy_no_tx", tx_q.size(), 0);
        TX_BUSY = 1'b0;
        wait_tx("alu_tx_count", 2);
        chk("alu_tx_lo", tx_q[0], 8'h34);
        chk("alu_tx_hi", tx_q[1], 8'h12);
        chk("alu_tx_gap", (tx_cyc[1] - tx_cyc[0]) >= 2, 1);
        tx_q.delete();
        tx_cyc.delete();

        // Unknown command then a normal write
        send_byte(8'h5A);
        chk("err_pulse", CMD_ERROR, 1);
        chk("err_no_wr", RF_WrEn, 0);
        tick(1);
        chk("err_one_cycle", CMD_ERROR, 0);
        chk("err_count", err_cnt, 1);
        chk("err_no_strobes", wr_cnt + rd_cnt, 4);
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h5C);
        chk("post_err_wr", RF_WrEn, 1);
        chk("post_err_addr", RF_Address, 4'h3);
        chk("post_err_data", RF_WrData, 8'h5C);

        // Reset mid-command
        send_byte(8'hAA);
        send_byte(8'h05);
        chk("pre_rst_addr", RF_Address, 4'h5);
        #2 RST = 1'b1;
        #1 chk("rst_async_outputs", all_out(), 0);
        tick(1);
        RST = 1'b0;
        tick(1);
        // FSM must be back in IDLE: 0xA6 is now an unknown command, not write data
        send_byte(8'hA6);
        chk("rst_idle_err", CMD_ERROR, 1);
        chk("rst_idle_no_wr", RF_WrEn, 0);
        chk("never_both_strobes", both_cnt, 0);

`ifdef CMD_TIMEOUT_EN
        begin
            int wr0, err0;
            tick(2);
            wr0  = wr_cnt;
            err0 = err_cnt;
            send_byte(8'hAA);
            tick(39990);
            chk("timeout_not_early", err_cnt, err0);
            tick(20);
            chk("timeout_err", err_cnt, err0 + 1);
            chk("timeout_no_wr", wr_cnt, wr0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
